ramtest_sequencer: RTL and testbench
====================================

Name: ramtest_sequencer

Overview:
- Controls the 8-bit SRAM tester (fast/slow test engine). Sits upstream of it, driving its rstf/rsts restart requests, and downstream of it, consuming test_in_progress/test_result.
- Runs one fast pass, then one slow pass, per sequence. Latches both verdicts, keeps saturating pass/fail tallies and drives a status LED for the test board.
- Same clock domain as the tester, so no synchronisers are needed on tester signals.

Parameters:
- AUTO_START, 1: 1 = begin a sequence automatically after the power-up run ends; 0 = wait for start.
- CONTINUOUS, 0: 1 = restart a new sequence from REPORT without waiting for start.
- ACK_TIMEOUT, 1024: cycles allowed for the tester to raise test_in_progress after a request.
- BLINK_BITS, 24: width of the LED divider; blink toggles on divider MSB.

Ports:
- clk  in  1  system clock, same as tester
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a sequence (user key, already debounced)
- test_in_progress  in  1  from tester
- test_result  in  1  from tester; valid when test_in_progress=0
- rstf  out  1  fast-test restart request to tester
- rsts  out  1  slow-test restart request to tester
- busy  out  1  sequence running
- done  out  1  at least one sequence has completed since reset
- fast_ok  out  1  latched fast verdict
- slow_ok  out  1  latched slow verdict
- ack_err  out  1  tester failed to acknowledge a request within ACK_TIMEOUT
- pass_count  out  8  sequences with fast_ok&slow_ok; saturates at 255
- fail_count  out  8  sequences failing either pass or ack; saturates at 255
- led  out  1  status LED

Behaviour:
- Reset values: rstf=rsts=0, busy=1, done=0, fast_ok=slow_ok=0, ack_err=0, counts=0, led=0, state=WAIT_BOOT, timeout counter=0.
- WAIT_BOOT: stay while test_in_progress=1. This covers the power-up run or a run in progress at reset. On 0: go to REQ_FAST if AUTO_START=1, else to IDLE with busy=0.
- IDLE: busy=0. On start=1: clear ack_err, busy=1, go to REQ_FAST.
- REQ_FAST: rstf=1 (level), timeout counter increments.
  - On test_in_progress=1: rstf=0, counter cleared, go to RUN_FAST.
  - On counter=ACK_TIMEOUT-1: rstf=0, ack_err=1, go to REPORT.
- RUN_FAST: wait for test_in_progress=0. On that edge, latch fast_ok<=test_result and go to REQ_SLOW.
- REQ_SLOW: same as REQ_FAST but drives rsts. The tester's slow-mode clock enable divides by 4, so acknowledge takes longer; ACK_TIMEOUT covers it.
- RUN_SLOW: wait for test_in_progress=0. Latch slow_ok<=test_result and go to REPORT.
- REPORT (one cycle): done=1.
  - If !ack_err & fast_ok & slow_ok: pass_count++. Otherwise fail_count++. Both saturate at 8'hFF.
  - Then go to REQ_FAST (with ack_err cleared) if CONTINUOUS=1, else to IDLE.
- rstf and rsts are never both 1. Both are 0 in every state except their REQ state.
- start is ignored in all states except IDLE. A start coinciding with rst is lost.
- Verdicts persist until overwritten by the next run of the same speed. On an ack timeout, verdicts of unrun passes keep their previous values.
- led:
  - busy: blink with divider MSB (divider free-runs, reset to 0).
  - idle with done=1 and last sequence passed: steady 1.
  - idle with last sequence failed: blink at divider bit BLINK_BITS-3 (4x rate).
  - idle with done=0: 0.
- Mid-run rst: outputs reset and state returns to WAIT_BOOT. No new request is issued until the tester halts, which avoids a request being missed while the tester is not in HALT.

Decomposition:
- Package ramtest_pkg holds:
  - state encodings (WAIT_BOOT, IDLE, REQ_FAST, RUN_FAST, REQ_SLOW, RUN_SLOW, REPORT), 3-bit;
  - the ACK_TIMEOUT default;
  - the 8-bit counter width.
- Sub-module status_led_blinker: divider plus mode select (off/steady/slow/fast). It takes clk, rst and a 2-bit mode, and outputs led.

Test Plan:
- Bench uses a tester model with 2-flop request sync, a HALT state, and a run length of 50 cycles (fast) / 200 cycles (slow).
- Power-up, AUTO_START=1, model passes both runs:
  - rstf high until in_progress rises, then rsts;
  - final state: fast_ok=1, slow_ok=1, pass_count=1, done=1, busy=0, led=1.
- Model fails slow run only: fast_ok=1, slow_ok=0, fail_count=1, pass_count=0, led fast-blink.
- Model never acknowledges rsts: after ACK_TIMEOUT=1024 cycles, rsts=0, ack_err=1, fail_count=1, busy=0.
- rst asserted mid RUN_SLOW with model still running:
  - state WAIT_BOOT, rstf=rsts=0 while in_progress=1;
  - new fast request issued only after in_progress falls.
- CONTINUOUS=1 with 300 passing sequences: pass_count saturates at 255 and stays there. rstf/rsts never high together.
- AUTO_START=0: no request after boot. A start pulse during RUN_FAST is ignored; a start in IDLE begins a sequence.

Source files
------------

// File: rtl/ramtest_pkg.sv
// ---------------------------------------------------------------------------
// ramtest_pkg
// Shared definitions for the SRAM tester sequencer:
//   - state_t     : sequencer FSM encoding (3-bit), also exported on the
//                   sequencer's debug output so checkers can bind to it
//   - led_mode_t  : status LED mode selector (off / steady / slow / fast)
//   - ACK_TIMEOUT_DEFAULT : default acknowledge window in clock cycles
//   - CNT_W / CNT_MAX     : width and ceiling of the pass/fail tallies
//   - sat_inc()           : saturating increment for the tallies
// ---------------------------------------------------------------------------
package ramtest_pkg;

  typedef enum logic [2:0] {
    WAIT_BOOT = 3'd0,
    IDLE      = 3'd1,
    REQ_FAST  = 3'd2,
    RUN_FAST  = 3'd3,
    REQ_SLOW  = 3'd4,
    RUN_SLOW  = 3'd5,
    REPORT    = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    LED_OFF    = 2'd0,
    LED_STEADY = 2'd1,
    LED_SLOW   = 2'd2,
    LED_FAST   = 2'd3
  } led_mode_t;

  localparam int ACK_TIMEOUT_DEFAULT = 1024;

  localparam int                CNT_W   = 8;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  // Tallies stick at their ceiling instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/status_led_blinker.sv
// ---------------------------------------------------------------------------
// status_led_blinker
// Free-running divider plus a mode select that drives one status LED.
//   clk   in   system clock
//   rst   in   synchronous active-high reset (divider and led cleared)
//   mode  in   2-bit led_mode_t: off, steady on, slow blink, fast blink
//   led   out  registered LED drive
// Slow blink follows the divider MSB; fast blink follows bit BLINK_BITS-3,
// which toggles four times as often.
// ---------------------------------------------------------------------------
module status_led_blinker
  import ramtest_pkg::*;
#(
  parameter int BLINK_BITS = 24
) (
  input  logic      clk,
  input  logic      rst,
  input  led_mode_t mode,
  output logic      led
);

  logic [BLINK_BITS-1:0] div;

  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
      led <= 1'b0;
    end else begin
      div <= div + 1'b1;
      case (mode)
        LED_OFF:    led <= 1'b0;
        LED_STEADY: led <= 1'b1;
        LED_SLOW:   led <= div[BLINK_BITS-1];
        LED_FAST:   led <= div[BLINK_BITS-3];
        default:    led <= 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/ramtest_sequencer.sv
// ---------------------------------------------------------------------------
// ramtest_sequencer
// Drives the 8-bit SRAM tester through one fast pass followed by one slow
// pass per sequence, latches both verdicts, keeps saturating pass/fail
// tallies and drives a status LED.
//
// Ports:
//   clk              in   system clock (shared with the tester)
//   rst              in   synchronous active-high reset
//   start            in   one-cycle request to begin a sequence (IDLE only)
//   test_in_progress in   tester busy flag
//   test_result      in   tester verdict, valid while test_in_progress=0
//   rstf / rsts      out  fast / slow restart request to the tester
//   busy             out  sequence running (also high while waiting on boot)
//   done             out  at least one sequence completed since reset
//   fast_ok/slow_ok  out  latched verdicts of the latest fast / slow run
//   ack_err          out  tester did not acknowledge a request in time
//   pass_count       out  passing sequences, saturating
//   fail_count       out  failing sequences (verdict or ack), saturating
//   led              out  status LED
//   state            out  current FSM state, for debug and checkers
//
// Request handshake: rstf/rsts is a level held high for the whole REQ state.
// The tester acknowledges by raising test_in_progress; the request drops on
// the edge that sees the acknowledge. If no acknowledge arrives within
// ACK_TIMEOUT cycles the request drops, ack_err is set and the sequence is
// reported as failed. At most one request is high at any time.
// ---------------------------------------------------------------------------
module ramtest_sequencer
  import ramtest_pkg::*;
#(
  parameter int AUTO_START  = 1,
  parameter int CONTINUOUS  = 0,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT,
  parameter int BLINK_BITS  = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             test_in_progress,
  input  logic             test_result,
  output logic             rstf,
  output logic             rsts,
  output logic             busy,
  output logic             done,
  output logic             fast_ok,
  output logic             slow_ok,
  output logic             ack_err,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             led,
  output state_t           state
);

  // Timeout counter only ever holds 0 .. ACK_TIMEOUT-1.
  localparam int               TMO_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             last_pass;   // outcome of the most recent REPORT
  led_mode_t        led_mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_BOOT;
      rstf       <= 1'b0;
      rsts       <= 1'b0;
      busy       <= 1'b1;
      done       <= 1'b0;
      fast_ok    <= 1'b0;
      slow_ok    <= 1'b0;
      ack_err    <= 1'b0;
      pass_count <= '0;
      fail_count <= '0;
      last_pass  <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      case (state)
        // Whatever the tester is doing at reset (power-up run or a run that
        // was interrupted) must finish first, otherwise a request issued now
        // could be missed because the tester only samples it in HALT.
        WAIT_BOOT: begin
          if (!test_in_progress) begin
            if (AUTO_START != 0) begin
              rstf  <= 1'b1;
              state <= REQ_FAST;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end

        IDLE: begin
          if (start) begin
            ack_err <= 1'b0;
            busy    <= 1'b1;
            rstf    <= 1'b1;
            state   <= REQ_FAST;
          end
        end

        REQ_FAST: begin
          if (test_in_progress) begin
            rstf    <= 1'b0;
            tmo_cnt <= '0;
            state   <= RUN_FAST;
          end else if (tmo_cnt == TMO_LAST) begin
            rstf    <= 1'b0;
            ack_err <= 1'b1;
            tmo_cnt <= '0;
            state   <= REPORT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        RUN_FAST: begin
          if (!test_in_progress) begin
            fast_ok <= test_result;
            rsts    <= 1'b1;
            state   <= REQ_SLOW;
          end
        end

        // The tester's slow mode advances only every fourth clock, so the
        // acknowledge here takes longer; the same window still covers it.
        REQ_SLOW: begin
          if (test_in_progress) begin
            rsts    <= 1'b0;
            tmo_cnt <= '0;
            state   <= RUN_SLOW;
          end else if (tmo_cnt == TMO_LAST) begin
            rsts    <= 1'b0;
            ack_err <= 1'b1;
            tmo_cnt <= '0;
            state   <= REPORT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        RUN_SLOW: begin
          if (!test_in_progress) begin
            slow_ok <= test_result;
            state   <= REPORT;
          end
        end

        // After an ack timeout the verdict of any pass that did not run still
        // holds its old value, so ack_err alone decides the failure.
        REPORT: begin
          done <= 1'b1;
          if (!ack_err && fast_ok && slow_ok) begin
            pass_count <= sat_inc(pass_count);
            last_pass  <= 1'b1;
          end else begin
            fail_count <= sat_inc(fail_count);
            last_pass  <= 1'b0;
          end
          if (CONTINUOUS != 0) begin
            ack_err <= 1'b0;
            rstf    <= 1'b1;
            state   <= REQ_FAST;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          rstf  <= 1'b0;
          rsts  <= 1'b0;
          state <= WAIT_BOOT;
        end
      endcase
    end
  end

  // LED priority: running blinks slowly; once idle, the last outcome shows
  // as steady (pass) or fast blink (fail); dark until a sequence completes.
  always_comb begin
    led_mode = LED_OFF;
    if (busy) begin
      led_mode = LED_SLOW;
    end else if (done) begin
      led_mode = last_pass ? LED_STEADY : LED_FAST;
    end
  end

  status_led_blinker #(
    .BLINK_BITS(BLINK_BITS)
  ) u_blinker (
    .clk  (clk),
    .rst  (rst),
    .mode (led_mode),
    .led  (led)
  );

endmodule

// File: tb/tb_ramtest_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ramtest_sequencer
// Three sequencer instances, each with its own tester model:
//   0 (a): AUTO_START=1, CONTINUOUS=0 -- pass, slow-fail, slow ack timeout,
//          reset in the middle of the slow run
//   1 (m): AUTO_START=0               -- manual start, start ignored mid-run
//   2 (c): CONTINUOUS=1               -- pass tally saturation
// Tester model: 2-flop request sync, HALT/RUN, fixed run lengths.
// ---------------------------------------------------------------------------
module tb_ramtest_sequencer;
  import ramtest_pkg::*;

  localparam int NI       = 3;
  localparam int W        = 19;
  localparam int BOOT_LEN = 30;
  localparam int S_RSTF   = 0;
  localparam int S_RSTS   = 1;
  localparam int S_TIP    = 2;
  localparam int S_BUSY   = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] rst, start, tip, tres;
  logic [NI-1:0] rstf, rsts, busy, done, fast_ok, slow_ok, ack_err, led;
  logic [7:0]    pass_count [NI];
  logic [7:0]    fail_count [NI];
  state_t        state      [NI];

  // tester model controls
  logic          mdl_init;
  logic [NI-1:0] fast_pass, slow_pass, ack_fast_en, ack_slow_en;

  ramtest_sequencer #(.AUTO_START(1), .CONTINUOUS(0), .ACK_TIMEOUT(1024), .BLINK_BITS(6)) dut_a (
    .clk(clk), .rst(rst[0]), .start(start[0]), .test_in_progress(tip[0]), .test_result(tres[0]),
    .rstf(rstf[0]), .rsts(rsts[0]), .busy(busy[0]), .done(done[0]), .fast_ok(fast_ok[0]),
    .slow_ok(slow_ok[0]), .ack_err(ack_err[0]), .pass_count(pass_count[0]),
    .fail_count(fail_count[0]), .led(led[0]), .state(state[0]));

  ramtest_sequencer #(.AUTO_START(0), .CONTINUOUS(0), .ACK_TIMEOUT(1024), .BLINK_BITS(6)) dut_m (
    .clk(clk), .rst(rst[1]), .start(start[1]), .test_in_progress(tip[1]), .test_result(tres[1]),
    .rstf(rstf[1]), .rsts(rsts[1]), .busy(busy[1]), .done(done[1]), .fast_ok(fast_ok[1]),
    .slow_ok(slow_ok[1]), .ack_err(ack_err[1]), .pass_count(pass_count[1]),
    .fail_count(fail_count[1]), .led(led[1]), .state(state[1]));

  ramtest_sequencer #(.AUTO_START(1), .CONTINUOUS(1), .ACK_TIMEOUT(1024), .BLINK_BITS(24)) dut_c (
    .clk(clk), .rst(rst[2]), .start(start[2]), .test_in_progress(tip[2]), .test_result(tres[2]),
    .rstf(rstf[2]), .rsts(rsts[2]), .busy(busy[2]), .done(done[2]), .fast_ok(fast_ok[2]),
    .slow_ok(slow_ok[2]), .ack_err(ack_err[2]), .pass_count(pass_count[2]),
    .fail_count(fail_count[2]), .led(led[2]), .state(state[2]));

  // ---------------- tester model ----------------
  logic [NI-1:0] rf_s1, rf_s2, rs_s1, rs_s2, m_run, m_slow;
  int            m_cnt [NI];

  function automatic int run_len(input int i, input bit slow);
    if (i == 2) return slow ? 40 : 10;
    return slow ? 200 : 50;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      rf_s1[i] <= rstf[i];
      rf_s2[i] <= rf_s1[i];
      rs_s1[i] <= rsts[i];
      rs_s2[i] <= rs_s1[i];
      if (mdl_init) begin
        m_run[i]  <= 1'b1;
        m_slow[i] <= 1'b0;
        m_cnt[i]  <= BOOT_LEN;
        tip[i]    <= 1'b1;
        tres[i]   <= 1'b0;
      end else if (m_run[i]) begin
        if (m_cnt[i] <= 1) begin
          m_run[i] <= 1'b0;
          tip[i]   <= 1'b0;
          tres[i]  <= m_slow[i] ? slow_pass[i] : fast_pass[i];
        end else begin
          m_cnt[i] <= m_cnt[i] - 1;
        end
      end else if (rf_s2[i] && ack_fast_en[i]) begin
        m_run[i]  <= 1'b1;
        m_slow[i] <= 1'b0;
        m_cnt[i]  <= run_len(i, 1'b0);
        tip[i]    <= 1'b1;
      end else if (rs_s2[i] && ack_slow_en[i]) begin
        m_run[i]  <= 1'b1;
        m_slow[i] <= 1'b1;
        m_cnt[i]  <= run_len(i, 1'b1);
        tip[i]    <= 1'b1;
      end
    end
  end

  // ---------------- request monitor ----------------
  int both_hi [NI];
  int rsts_cycles [NI];
  int rstf_cycles [NI];

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rstf[i] === 1'b1 && rsts[i] === 1'b1) both_hi[i] <= both_hi[i] + 1;
      if (rsts[i] === 1'b1) rsts_cycles[i] <= rsts_cycles[i] + 1;
      if (rstf[i] === 1'b1) rstf_cycles[i] <= rstf_cycles[i] + 1;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_m[$];
  logic [W-1:0] exp_q_c[$];

  function automatic logic [W-1:0] pack(input logic f, input logic s, input logic a,
                                        input int p, input int fc);
    logic [7:0] p8;
    logic [7:0] f8;
    p8 = p[7:0];
    f8 = fc[7:0];
    return {f, s, a, p8, f8};
  endfunction

  function automatic logic [W-1:0] obs(input int i);
    return {fast_ok[i], slow_ok[i], ack_err[i], pass_count[i], fail_count[i]};
  endfunction

  task automatic sb_push(input int i, input logic [W-1:0] v);
    case (i)
      0:       exp_q_a.push_back(v);
      1:       exp_q_m.push_back(v);
      default: exp_q_c.push_back(v);
    endcase
  endtask

  task automatic sb_check(input int i, input string tag);
    logic [W-1:0] e;
    int           sz;
    case (i)
      0:       sz = exp_q_a.size();
      1:       sz = exp_q_m.size();
      default: sz = exp_q_c.size();
    endcase
    if (sz == 0) begin
      check({tag, "_sb_nonempty"}, 32'(0), 32'(1));
    end else begin
      case (i)
        0:       e = exp_q_a.pop_front();
        1:       e = exp_q_m.pop_front();
        default: e = exp_q_c.pop_front();
      endcase
      check(tag, 32'(obs(i)), 32'(e));
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic sig(input int i, input int sel);
    case (sel)
      S_RSTF:  return rstf[i];
      S_RSTS:  return rsts[i];
      S_TIP:   return tip[i];
      S_BUSY:  return busy[i];
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input int i, input int sel, input logic val, input int budget,
                          input string tag);
    int n;
    n = 0;
    while (sig(i, sel) !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_reached"}, 32'(sig(i, sel) === val), 32'(1));
  endtask

  task automatic wait_state(input int i, input state_t s, input int budget, input string tag);
    int n;
    n = 0;
    while (state[i] !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_reached"}, 32'(state[i]), 32'(s));
  endtask

  task automatic pulse_start(input int i);
    @(posedge clk);
    #1 start[i] = 1'b1;
    @(posedge clk);
    #1 start[i] = 1'b0;
    @(negedge clk);
  endtask

  task automatic count_toggles(input int i, input int cycles, output int t);
    logic prev;
    t    = 0;
    prev = led[i];
    repeat (cycles) begin
      @(negedge clk);
      if (led[i] !== prev) begin
        t++;
        prev = led[i];
      end
    end
  endtask

  // ---------------- instance a: auto start, single sequences ----------------
  task automatic thread_a();
    int ep, ef, t, snap;
    ep = 0;
    ef = 0;
    check("a_rst_state", 32'(state[0]), 32'(WAIT_BOOT));
    check("a_rst_rstf", 32'(rstf[0]), 32'(0));
    check("a_rst_rsts", 32'(rsts[0]), 32'(0));
    check("a_rst_busy", 32'(busy[0]), 32'(1));
    check("a_rst_done", 32'(done[0]), 32'(0));
    check("a_rst_fast_ok", 32'(fast_ok[0]), 32'(0));
    check("a_rst_slow_ok", 32'(slow_ok[0]), 32'(0));
    check("a_rst_ack_err", 32'(ack_err[0]), 32'(0));
    check("a_rst_pass", 32'(pass_count[0]), 32'(0));
    check("a_rst_fail", 32'(fail_count[0]), 32'(0));
    check("a_rst_led", 32'(led[0]), 32'(0));

    // power-up run ends, auto sequence, both passes good
    ep++;
    sb_push(0, pack(1'b1, 1'b1, 1'b0, ep, ef));
    wait_sig(0, S_RSTF, 1'b1, 100, "a_boot_req");
    check("a_boot_req_state", 32'(state[0]), 32'(REQ_FAST));
    wait_sig(0, S_TIP, 1'b1, 50, "a_fast_ack");
    @(negedge clk);
    check("a_rstf_drop", 32'(rstf[0]), 32'(0));
    check("a_run_fast", 32'(state[0]), 32'(RUN_FAST));
    wait_sig(0, S_RSTS, 1'b1, 200, "a_slow_req");
    check("a_rstf_off_in_slow", 32'(rstf[0]), 32'(0));
    check("a_req_slow", 32'(state[0]), 32'(REQ_SLOW));
    wait_sig(0, S_BUSY, 1'b0, 1000, "a_seq1_end");
    sb_check(0, "a_seq1");
    check("a_seq1_done", 32'(done[0]), 32'(1));
    repeat (2) @(negedge clk);
    check("a_led_pass", 32'(led[0]), 32'(1));
    count_toggles(0, 64, t);
    check("a_led_steady", 32'(t), 32'(0));

    // slow run fails
    slow_pass[0] = 1'b0;
    ef++;
    sb_push(0, pack(1'b1, 1'b0, 1'b0, ep, ef));
    pulse_start(0);
    check("a_seq2_busy", 32'(busy[0]), 32'(1));
    wait_sig(0, S_BUSY, 1'b0, 1000, "a_seq2_end");
    sb_check(0, "a_seq2");
    repeat (2) @(negedge clk);
    count_toggles(0, 64, t);
    check("a_led_fast_blink", 32'(t), 32'(8));

    // tester never acknowledges rsts; slow verdict keeps its old value
    slow_pass[0]   = 1'b1;
    ack_slow_en[0] = 1'b0;
    ef++;
    sb_push(0, pack(1'b1, 1'b0, 1'b1, ep, ef));
    snap = rsts_cycles[0];
    pulse_start(0);
    wait_sig(0, S_BUSY, 1'b0, 2000, "a_seq3_end");
    sb_check(0, "a_seq3_timeout");
    check("a_tmo_rsts_low", 32'(rsts[0]), 32'(0));
    check("a_tmo_len", 32'(rsts_cycles[0] - snap), 32'(1024));
    repeat (4) @(negedge clk);
    ack_slow_en[0] = 1'b1;

    // reset in the middle of the slow run
    pulse_start(0);
    wait_state(0, RUN_SLOW, 500, "a_seq4_run_slow");
    repeat (20) @(negedge clk);
    @(posedge clk);
    #1 rst[0] = 1'b1;
    @(posedge clk);
    #1 rst[0] = 1'b0;
    @(negedge clk);
    check("a_mid_rst_state", 32'(state[0]), 32'(WAIT_BOOT));
    check("a_mid_rst_rstf", 32'(rstf[0]), 32'(0));
    check("a_mid_rst_rsts", 32'(rsts[0]), 32'(0));
    check("a_mid_rst_busy", 32'(busy[0]), 32'(1));
    check("a_mid_rst_done", 32'(done[0]), 32'(0));
    check("a_mid_rst_fail", 32'(fail_count[0]), 32'(0));
    ep = 1;
    ef = 0;
    snap = rstf_cycles[0];
    wait_sig(0, S_TIP, 1'b0, 400, "a_drain");
    check("a_no_req_while_running", 32'(rstf_cycles[0] - snap), 32'(0));
    wait_sig(0, S_RSTF, 1'b1, 10, "a_req_after_halt");
    check("a_req_after_halt_state", 32'(state[0]), 32'(REQ_FAST));
    sb_push(0, pack(1'b1, 1'b1, 1'b0, ep, ef));
    wait_sig(0, S_BUSY, 1'b0, 1000, "a_seq5_end");
    sb_check(0, "a_seq5");
  endtask

  // ---------------- instance m: manual start ----------------
  task automatic thread_m();
    int t, snap;
    repeat (100) @(negedge clk);
    check("m_boot_idle", 32'(state[1]), 32'(IDLE));
    check("m_boot_busy", 32'(busy[1]), 32'(0));
    check("m_boot_no_req", 32'(rstf_cycles[1]), 32'(0));
    check("m_boot_done", 32'(done[1]), 32'(0));
    count_toggles(1, 64, t);
    check("m_led_off_toggles", 32'(t), 32'(0));
    check("m_led_off", 32'(led[1]), 32'(0));

    sb_push(1, pack(1'b1, 1'b1, 1'b0, 1, 0));
    pulse_start(1);
    wait_state(1, RUN_FAST, 100, "m_run_fast");
    pulse_start(1);
    check("m_start_ignored", 32'(state[1]), 32'(RUN_FAST));
    wait_sig(1, S_BUSY, 1'b0, 1000, "m_seq1_end");
    sb_check(1, "m_seq1");
    snap = rstf_cycles[1];
    repeat (50) @(negedge clk);
    check("m_stays_idle", 32'(state[1]), 32'(IDLE));
    check("m_no_extra_req", 32'(rstf_cycles[1] - snap), 32'(0));

    sb_push(1, pack(1'b1, 1'b1, 1'b0, 2, 0));
    pulse_start(1);
    check("m_seq2_busy", 32'(busy[1]), 32'(1));
    wait_sig(1, S_BUSY, 1'b0, 1000, "m_seq2_end");
    sb_check(1, "m_seq2");
  endtask

  // ---------------- instance c: continuous, saturation ----------------
  task automatic thread_c();
    int k, n, e;
    k = 0;
    n = 0;
    while (k < 300 && n < 40000) begin
      @(negedge clk);
      n++;
      if (state[2] == REPORT) begin
        k++;
        if (k == 1 || k == 254 || k == 255 || k == 256 || k == 300) begin
          e = (k > 255) ? 255 : k;
          sb_push(2, pack(1'b1, 1'b1, 1'b0, e, 0));
          @(negedge clk);
          n++;
          sb_check(2, $sformatf("c_seq%0d", k));
        end
      end
    end
    check("c_reports_300", 32'(k), 32'(300));
    check("c_still_busy", 32'(busy[2]), 32'(1));
  endtask

  // ---------------- main ----------------
  initial begin
    rst         = '1;
    start       = '0;
    mdl_init    = 1'b1;
    fast_pass   = '1;
    slow_pass   = '1;
    ack_fast_en = '1;
    ack_slow_en = '1;
    repeat (3) @(posedge clk);
    #1;
    rst      = '0;
    mdl_init = 1'b0;
    @(negedge clk);
    fork
      thread_a();
      thread_m();
      thread_c();
    join
    for (int i = 0; i < NI; i++) begin
      check($sformatf("req_exclusive_%0d", i), 32'(both_hi[i]), 32'(0));
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
